start_control: RTL and testbench

START_CONTROL -- requirements
Module: start_control

---
 rtl/start_control_pkg.sv | 8 +
 rtl/start_if.sv | 13 +
 rtl/start_debounce.sv | 25 ++
 rtl/start_control.sv | 86 ++++++++
 tb/tb_start_control.sv | 119 +++++++++++
 5 files changed

// File: rtl/start_control_pkg.sv
// start_control_pkg: shared state encoding and default timing for the start controller
package start_control_pkg;
  localparam int DEF_POR_CYCLES = 16;
  localparam int DEF_STRT2_CYCLES = 8;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_SBY_HOLD = 32;
  typedef enum logic [2:0] {ST_OFF, ST_S1, ST_S2, ST_GO, ST_RUN, ST_STBY} state_t;
endpackage

// File: rtl/start_if.sv
// start_if: panel/supply inputs and start/pulse outputs of the start controller
interface start_if;
  logic pwr_ok, alarm, sby_btn, mstrt_btn, mstp_sw;
  logic strt1, strt2, goj1, alga, mstrtp, sby, mstp, run;
  modport master (
    output pwr_ok, alarm, sby_btn, mstrt_btn, mstp_sw,
    input  strt1, strt2, goj1, alga, mstrtp, sby, mstp, run
  );
  modport slave (
    input  pwr_ok, alarm, sby_btn, mstrt_btn, mstp_sw,
    output strt1, strt2, goj1, alga, mstrtp, sby, mstp, run
  );
endinterface

// File: rtl/start_debounce.sv
// start_debounce: 2-flop synchronizer followed by a consecutive-sample debouncer
module start_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = cnt == CW'(DEBOUNCE - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level <= (sync[1] != level && hit) ? sync[1] : level;
      cnt <= (sync[1] == level || hit) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/start_control.sv
// start_control: power-on start sequencer with standby, alarm restart and panel pulses
module start_control
  import start_control_pkg::*;
#(
  parameter int POR_CYCLES = DEF_POR_CYCLES,
  parameter int STRT2_CYCLES = DEF_STRT2_CYCLES,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int SBY_HOLD = DEF_SBY_HOLD
) (
  input logic sim_clk,
  input logic sim_rst,
  start_if.slave bus
);
  localparam int CNT_W = $clog2(POR_CYCLES + STRT2_CYCLES + SBY_HOLD) + 1;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] pwr_s;
  logic [2:0] alm_s;
  logic sby_db, mstrt_db, mstp_db, sby_q, mstrt_q;
  logic pwr, alarm_rise, sby_rise, mstrt_rise, in_run, alga_n;
  start_debounce #(.DEBOUNCE(DEBOUNCE)) u_sby (.clk(sim_clk), .rst(sim_rst), .raw(bus.sby_btn), .level(sby_db));
  start_debounce #(.DEBOUNCE(DEBOUNCE)) u_mstrt (.clk(sim_clk), .rst(sim_rst), .raw(bus.mstrt_btn), .level(mstrt_db));
  start_debounce #(.DEBOUNCE(DEBOUNCE)) u_mstp (.clk(sim_clk), .rst(sim_rst), .raw(bus.mstp_sw), .level(mstp_db));
  assign pwr = pwr_s[1];
  assign alarm_rise = alm_s[1] & ~alm_s[2];
  assign sby_rise = sby_db & ~sby_q;
  assign mstrt_rise = mstrt_db & ~mstrt_q;
  assign in_run = pwr && state == ST_RUN;
  assign alga_n = in_run && alarm_rise;
  always_ff @(posedge sim_clk or posedge sim_rst)
    if (sim_rst) begin
      state <= ST_OFF;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
    end
  always_comb begin
    nxt = state;
    cnt_n = '0;
    case (state)
      ST_OFF: nxt = ST_S1;
      ST_S1: if (cnt == CNT_W'(POR_CYCLES - 1)) nxt = ST_S2; else cnt_n = cnt + 1'b1;
      ST_S2: if (cnt == CNT_W'(STRT2_CYCLES - 1)) nxt = ST_GO; else cnt_n = cnt + 1'b1;
      ST_GO: nxt = ST_RUN;
      ST_RUN: if (sby_db) begin
        if (cnt == CNT_W'(SBY_HOLD - 1)) nxt = ST_STBY; else cnt_n = cnt + 1'b1;
      end
      ST_STBY: if (sby_rise) nxt = ST_S2;
      default: nxt = ST_OFF;
    endcase
    if (!pwr) begin
      nxt = ST_OFF;
      cnt_n = '0;
    end
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge sim_clk or posedge sim_rst)
    if (sim_rst) begin
      pwr_s <= '0;
      alm_s <= '0;
      sby_q <= 1'b0;
      mstrt_q <= 1'b0;
      bus.strt1 <= 1'b1;
      bus.strt2 <= 1'b0;
      bus.goj1 <= 1'b0;
      bus.alga <= 1'b0;
      bus.mstrtp <= 1'b0;
      bus.sby <= 1'b0;
      bus.mstp <= 1'b0;
      bus.run <= 1'b0;
    end else begin
      pwr_s <= {pwr_s[0], bus.pwr_ok};
      alm_s <= {alm_s[1:0], bus.alarm};
      sby_q <= sby_db;
      mstrt_q <= mstrt_db;
      bus.strt1 <= nxt == ST_OFF || nxt == ST_S1;
      bus.strt2 <= nxt == ST_S2;
      bus.goj1 <= nxt == ST_GO || alga_n;
      bus.alga <= alga_n;
      bus.mstrtp <= in_run && mstrt_rise;
      bus.sby <= nxt == ST_STBY;
      bus.mstp <= nxt == ST_RUN && mstp_db;
      bus.run <= nxt == ST_RUN;
    end
endmodule

// File: tb/tb_start_control.sv
// tb_start_control: directed vector and sequence checks of the start controller
module tb_start_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [7:0] O_S1 = 8'h80, O_S2 = 8'h40, O_GO = 8'h20, O_RUN = 8'h01;
  localparam logic [7:0] O_SBY = 8'h04, O_ALG = 8'h31, O_MS = 8'h09, O_MP = 8'h03;
  typedef struct {
    int n;
    logic [4:0] stim;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[16];
  start_if bus();
  start_control dut (.sim_clk(clk), .sim_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [4:0] v);
    {bus.pwr_ok, bus.alarm, bus.sby_btn, bus.mstrt_btn, bus.mstp_sw} = v;
  endtask
  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {bus.strt1, bus.strt2, bus.goj1, bus.alga, bus.mstrtp, bus.sby, bus.mstp, bus.run};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (strt1 strt2 goj1 alga mstrtp sby mstp run)", name, got, exp);
    end
  endtask
  task automatic run_chk(input int n, input string name, input logic [7:0] exp);
    step(n);
    check(name, exp);
  endtask
  initial begin
    vecs = '{
      '{1, 5'b10000, O_S1}, '{17, 5'b10000, O_S1}, '{1, 5'b10000, O_S2}, '{7, 5'b10000, O_S2},
      '{1, 5'b10000, O_GO}, '{1, 5'b10000, O_RUN}, '{5, 5'b10000, O_RUN}, '{2, 5'b11000, O_RUN},
      '{1, 5'b11000, O_ALG}, '{1, 5'b11000, O_RUN}, '{6, 5'b10010, O_RUN}, '{1, 5'b10010, O_MS},
      '{1, 5'b10010, O_RUN}, '{6, 5'b10001, O_RUN}, '{1, 5'b10001, O_MP}, '{7, 5'b10000, O_RUN}
    };
    drive(5'b10000);
    step(2);
    check("reset_state", O_S1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stim);
      run_chk(vecs[i].n, $sformatf("vec%0d", i), vecs[i].exp);
    end
    for (int g = 0; g < 3; g++) begin
      drive(5'b10100);
      step(3);
      drive(5'b10000);
      step(3);
    end
    check("bounce_ignored", O_RUN);
    drive(5'b10100);
    run_chk(37, "sby_hold_end", O_RUN);
    run_chk(1, "sby_enter", O_SBY);
    run_chk(2, "sby_held", O_SBY);
    drive(5'b10011);
    run_chk(7, "stby_no_mstrtp_mstp", O_SBY);
    drive(5'b10000);
    run_chk(3, "stby_release", O_SBY);
    drive(5'b10100);
    run_chk(6, "stby_wait", O_SBY);
    run_chk(1, "wake_s2", O_S2);
    drive(5'b11100);
    run_chk(3, "s2_alarm_ignored", O_S2);
    drive(5'b11000);
    run_chk(4, "wake_s2_end", O_S2);
    run_chk(1, "wake_goj1", O_GO);
    run_chk(1, "wake_run", O_RUN);
    run_chk(3, "run_alarm_level", O_RUN);
    drive(5'b00000);
    run_chk(3, "pwr_drop_off", O_S1);
    drive(5'b10000);
    run_chk(18, "s1_replay_end", O_S1);
    run_chk(1, "s2_replay", O_S2);
    drive(5'b00000);
    run_chk(2, "s2_pwr_drop_hold", O_S2);
    run_chk(1, "s2_pwr_drop", O_S1);
    drive(5'b10000);
    run_chk(18, "s1_full", O_S1);
    run_chk(1, "s2_full", O_S2);
    run_chk(8, "goj1_full", O_GO);
    run_chk(1, "run_full", O_RUN);
    drive(5'b10100);
    run_chk(35, "sim_pre", O_RUN);
    drive(5'b11100);
    run_chk(3, "sim_alga_and_sby", 8'h34);
    run_chk(1, "sim_after", O_SBY);
    drive(5'b10000);
    rst = 1'b1;
    #1;
    check("reset_async", O_S1);
    step(1);
    rst = 1'b0;
    run_chk(1, "rst_c0", O_S1);
    run_chk(8, "rst_mid_s1", O_S1);
    rst = 1'b1;
    #1;
    check("reset_mid_s1", O_S1);
    step(1);
    rst = 1'b0;
    run_chk(1, "rst2_c0", O_S1);
    run_chk(17, "rst2_s1_end", O_S1);
    run_chk(1, "rst2_s2", O_S2);
    run_chk(8, "rst2_goj1", O_GO);
    run_chk(1, "rst2_run", O_RUN);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
